// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: NOP encoding, reset PC default and the
// branch/jump opcode and funct values used by decode.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_RTYPE  = 6'h00,
    OP_REGIMM = 6'h01,  // BLTZ lives under REGIMM
    OP_J      = 6'h02,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_BLEZ   = 6'h06,
    OP_BGTZ   = 6'h07
  } opcode_t;

  localparam logic [4:0] RT_BLTZ  = 5'h00;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clear loads a bubble, en loads a fetched
// instruction, otherwise the register holds.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (clr) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (en) begin
      instr    <= d_instr;
      pc_plus4 <= d_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register and next-PC mux, imem ready handshake,
// IF/ID register and a saturating count of wait-state bubbles.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcD,
  input  logic [31:0]      target_D,
  output logic [31:0]      PCF,
  output logic [31:0]      instrD,
  output logic [31:0]      PCPlus4D,
  output logic             validD,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [31:0] pc_next;
  logic [31:0] pc_plus4_f;
  logic [31:0] target_aligned;
  logic        redirect;
  logic        hold_pc;
  logic        squash;
  logic        bubble_in;
  logic        wait_bubble;

  assign pc_plus4_f     = pc_plus4(PCF);
  assign target_aligned = target_D & 32'hFFFF_FFFC;
  assign redirect       = PCSrcD & ~StallD;
  // A StallD without StallF would drop the fetched word, so the PC holds too.
  assign hold_pc        = StallF | StallD;
  assign squash         = redirect & (DELAY_SLOT == 1'b0);
  assign imem_addr      = PCF;

  always_comb begin
    pc_next = pc_plus4_f;
    if (redirect)         pc_next = target_aligned;
    else if (hold_pc)     pc_next = PCF;
    else if (!imem_ready) pc_next = PCF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) PCF <= RESET_PC & 32'hFFFF_FFFC;
    else     PCF <= pc_next;
  end

  // Bubble sources below StallD in priority; only pure imem wait states are counted.
  assign bubble_in   = FlushD | (~StallD & (squash | StallF | ~imem_ready));
  assign wait_bubble = ~FlushD & ~StallD & ~squash & ~StallF & ~imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bubble_cnt <= '0;
    else if (wait_bubble && (bubble_cnt != '1))
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .en         (~StallD),
    .clr        (bubble_in),
    .d_instr    (imem_rdata),
    .d_pc_plus4 (pc_plus4_f),
    .instr      (instrD),
    .pc_plus4   (PCPlus4D),
    .valid      (validD)
  );

endmodule
